johnson_seq_monitor: RTL and testbench

- Downstream checker for the 2-phase ring/Johnson counter stage.
- Samples a Johnson-coded word every valid cycle and validates code legality and successor order.
- Decodes the word to a binary phase index and a one-hot phase vector.
- Reports lock/loss-of-lock, sequence errors and full rotations to the control/status logic.

---
 rtl/johnson_seq_monitor.sv | 198 +++++++++++++++++++
 tb/tb_johnson_seq_monitor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_seq_monitor.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// johnson_seq_monitor
//
// Downstream checker for a 2-phase ring/Johnson counter stage. Each cycle
// with in_valid high, the incoming Johnson word is checked for legality and
// for being the successor of the previous legal word. Legal words are also
// decoded to a binary phase index and a one-hot phase vector. A small
// IDLE/ACQ/LOCKED tracker reports lock, loss of lock, illegal codes and
// full rotations.
//
// Parameters:
//   WIDTH    Johnson code width N (>= 2); the sequence length is 2N
//   LOCK_CNT consecutive successor transitions needed to lock (>= 1)
//   CNT_W    width of err_cnt and rot_cnt
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   jcode is sampled this cycle
//   jcode      Johnson code from the counter stage
//   clr_err    clears err_sticky and err_cnt (a same-cycle error wins)
//   phase      decoded phase of the last legal sample
//   phase_oh   one-hot of phase
//   locked     high while in LOCKED
//   illegal    one-cycle pulse: sampled code is not a Johnson code
//   seq_err    one-cycle pulse: lock lost
//   err_sticky set by illegal/seq_err, held until clr_err
//   err_cnt    saturating error count
//   rot_tick   one-cycle pulse per full rotation while locked
//   rot_cnt    wrapping rotation count
//
// Configuration macro:
//   JSM_ROT_CNT_EN  when defined, rot_tick/rot_cnt logic is built; otherwise
//                   both outputs are tied to zero and no rotation flops exist.
// -----------------------------------------------------------------------------
module johnson_seq_monitor #(
  parameter int WIDTH    = 2,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8,
  localparam int PW      = $clog2(2 * WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   jcode,
  input  logic               clr_err,
  output logic [PW-1:0]      phase,
  output logic [2*WIDTH-1:0] phase_oh,
  output logic               locked,
  output logic               illegal,
  output logic               seq_err,
  output logic               err_sticky,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               rot_tick,
  output logic [CNT_W-1:0]   rot_cnt
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACQ    = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [1:0]         state, nxt_state;
  logic [GW-1:0]      good, nxt_good;
  logic [WIDTH-1:0]   prev;
  logic               legal;
  logic               is_succ;
  logic [PW-1:0]      phase_calc;
  logic               ev_ill, ev_seq, err_ev;

  // Decode: a Johnson word has at most one 0/1 boundary between adjacent
  // bits. That single rule admits exactly the 2N codes 1..10..0 and 0..01..1.
  always_comb begin
    int trans;
    int pc;
    int pv;
    trans = 0;
    pc    = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (jcode[i] != jcode[i+1]) trans++;
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (jcode[i]) pc++;
    end
    legal      = (trans <= 1);
    // MSB set (or all-zero) is the filling half of the cycle, otherwise the
    // draining half counts back down from 2N.
    pv         = (jcode[WIDTH-1] || pc == 0) ? pc : 2 * WIDTH - pc;
    phase_calc = PW'(pv);
  end

  assign is_succ = (jcode == {~prev[0], prev[WIDTH-1:1]});

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    nxt_state = state;
    nxt_good  = good;
    ev_ill    = 1'b0;
    ev_seq    = 1'b0;
    if (in_valid) begin
      if (!legal) begin
        ev_ill    = 1'b1;
        ev_seq    = (state == S_LOCKED);
        nxt_state = S_IDLE;
        nxt_good  = '0;
      end else begin
        case (state)
          S_IDLE: begin
            nxt_state = S_ACQ;
            nxt_good  = '0;
          end
          S_ACQ: begin
            if (!is_succ) begin
              nxt_good = '0;
            end else if (good == GW'(LOCK_CNT - 1)) begin
              nxt_state = S_LOCKED;
              nxt_good  = '0;
            end else begin
              nxt_good = good + GW'(1);
            end
          end
          S_LOCKED: begin
            if (!is_succ) begin
              nxt_state = S_ACQ;
              nxt_good  = '0;
              ev_seq    = 1'b1;
            end
          end
          default: begin
            nxt_state = S_IDLE;
            nxt_good  = '0;
          end
        endcase
      end
    end
  end

  assign err_ev = ev_ill | ev_seq;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      good       <= '0;
      prev       <= '0;
      phase      <= '0;
      phase_oh   <= (2 * WIDTH)'(1);
      locked     <= 1'b0;
      illegal    <= 1'b0;
      seq_err    <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state   <= nxt_state;
      good    <= nxt_good;
      locked  <= (nxt_state == S_LOCKED);
      illegal <= ev_ill;
      seq_err <= ev_seq;
      if (in_valid && legal) begin
        prev     <= jcode;
        phase    <= phase_calc;
        phase_oh <= (2 * WIDTH)'(1) << phase_calc;
      end
      // A new error in the same cycle as clr_err overrides the clear.
      if (err_ev) begin
        err_sticky <= 1'b1;
        if (clr_err)            err_cnt <= CNT_W'(1);
        else if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      end else if (clr_err) begin
        err_sticky <= 1'b0;
        err_cnt    <= '0;
      end
    end
  end

`ifdef JSM_ROT_CNT_EN
  // The transition that enters LOCKED is seen in ACQ, so it never counts.
  logic rot_hit;
  assign rot_hit = in_valid && legal && (state == S_LOCKED) && is_succ &&
                   (phase_calc == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rot_tick <= 1'b0;
      rot_cnt  <= '0;
    end else begin
      rot_tick <= rot_hit;
      if (rot_hit) rot_cnt <= rot_cnt + CNT_W'(1);
    end
  end
`else
  assign rot_tick = 1'b0;
  assign rot_cnt  = '0;
`endif

endmodule

// File: tb/tb_johnson_seq_monitor.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_johnson_seq_monitor
//
// Two instances: d2 (WIDTH=2, LOCK_CNT=4, CNT_W=8) covers lock, rotation,
// skip, valid gaps, repeat, clear and mid-lock reset; d3 (WIDTH=3,
// LOCK_CNT=2, CNT_W=3) covers illegal codes, the clear/error collision and
// err_cnt saturation. Each directed step pushes its hand-computed outputs to
// a scoreboard; a monitor pops and compares on the falling edge after the
// sampling edge. Rotation expectations collapse to zero when JSM_ROT_CNT_EN
// is not defined.
// -----------------------------------------------------------------------------
module tb_johnson_seq_monitor;

`ifdef JSM_ROT_CNT_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;

  logic       v2, clr2;
  logic [1:0] j2;
  logic [1:0] ph2;
  logic [3:0] oh2;
  logic       lk2, il2, se2, st2, rt2;
  logic [7:0] ec2, rc2;

  logic       v3, clr3;
  logic [2:0] j3;
  logic [2:0] ph3;
  logic [5:0] oh3;
  logic       lk3, il3, se3, st3, rt3;
  logic [2:0] ec3, rc3;

  johnson_seq_monitor #(.WIDTH(2), .LOCK_CNT(4), .CNT_W(8)) d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .jcode(j2), .clr_err(clr2),
    .phase(ph2), .phase_oh(oh2), .locked(lk2), .illegal(il2), .seq_err(se2),
    .err_sticky(st2), .err_cnt(ec2), .rot_tick(rt2), .rot_cnt(rc2)
  );

  johnson_seq_monitor #(.WIDTH(3), .LOCK_CNT(2), .CNT_W(3)) d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .jcode(j3), .clr_err(clr3),
    .phase(ph3), .phase_oh(oh3), .locked(lk3), .illegal(il3), .seq_err(se3),
    .err_sticky(st3), .err_cnt(ec3), .rot_tick(rt3), .rot_cnt(rc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int sel;
    int due;
    int ph, lk, ill, se, st, ec, rt, rc;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus on the selected instance and queue its result.
  task automatic step(input int sel, input bit r, input bit v,
                      input logic [2:0] code, input bit clr,
                      input int ph, input int lk, input int ill, input int se,
                      input int st, input int ec, input int rt, input int rc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r;
    v2 = 1'b0; clr2 = 1'b0; v3 = 1'b0; clr3 = 1'b0;
    if (sel == 2) begin
      v2 = v; j2 = code[1:0]; clr2 = clr;
    end else begin
      v3 = v; j3 = code; clr3 = clr;
    end
    e.sel = sel; e.due = cyc + 1;
    e.ph = ph; e.lk = lk; e.ill = ill; e.se = se; e.st = st; e.ec = ec;
    e.rt = ROT_EN ? rt : 0;
    e.rc = ROT_EN ? rc : 0;
    sb.push_back(e);
  endtask

  task automatic s2(input bit r, input bit v, input logic [2:0] code,
                    input bit clr, input int ph, input int lk, input int ill,
                    input int se, input int st, input int ec, input int rt,
                    input int rc);
    step(2, r, v, code, clr, ph, lk, ill, se, st, ec, rt, rc);
  endtask

  task automatic s3(input bit r, input bit v, input logic [2:0] code,
                    input bit clr, input int ph, input int lk, input int ill,
                    input int se, input int st, input int ec, input int rt,
                    input int rc);
    step(3, r, v, code, clr, ph, lk, ill, se, st, ec, rt, rc);
  endtask

  // Monitor: compare the queued expectation once its sampling edge has passed.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        string p;
        e = sb.pop_front();
        p = $sformatf("d%0d@%0d", e.sel, e.due);
        if (e.sel == 2) begin
          check({p, ".phase"},    32'(ph2), 32'(e.ph));
          check({p, ".phase_oh"}, 32'(oh2), 32'(1) << e.ph);
          check({p, ".locked"},   32'(lk2), 32'(e.lk));
          check({p, ".illegal"},  32'(il2), 32'(e.ill));
          check({p, ".seq_err"},  32'(se2), 32'(e.se));
          check({p, ".sticky"},   32'(st2), 32'(e.st));
          check({p, ".err_cnt"},  32'(ec2), 32'(e.ec));
          check({p, ".rot_tick"}, 32'(rt2), 32'(e.rt));
          check({p, ".rot_cnt"},  32'(rc2), 32'(e.rc));
        end else begin
          check({p, ".phase"},    32'(ph3), 32'(e.ph));
          check({p, ".phase_oh"}, 32'(oh3), 32'(1) << e.ph);
          check({p, ".locked"},   32'(lk3), 32'(e.lk));
          check({p, ".illegal"},  32'(il3), 32'(e.ill));
          check({p, ".seq_err"},  32'(se3), 32'(e.se));
          check({p, ".sticky"},   32'(st3), 32'(e.st));
          check({p, ".err_cnt"},  32'(ec3), 32'(e.ec));
          check({p, ".rot_tick"}, 32'(rt3), 32'(e.rt));
          check({p, ".rot_cnt"},  32'(rc3), 32'(e.rc));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    v2 = 1'b0; clr2 = 1'b0; j2 = '0;
    v3 = 1'b0; clr3 = 1'b0; j3 = '0;

    // ---- d2: reset, then acquire: lock after the 5th valid sample
    //    r  v  code    clr  ph lk il se st ec rt rc
    s2(0, 0, 3'b000, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    s2(0, 0, 3'b000, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    s2(1, 1, 3'b000, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    s2(1, 1, 3'b010, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    s2(1, 1, 3'b011, 0,  2, 0, 0, 0, 0, 0, 0, 0);
    s2(1, 1, 3'b001, 0,  3, 0, 0, 0, 0, 0, 0, 0);
    s2(1, 1, 3'b000, 0,  0, 1, 0, 0, 0, 0, 0, 0);
    // full rotation while locked
    s2(1, 1, 3'b010, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    s2(1, 1, 3'b011, 0,  2, 1, 0, 0, 0, 0, 0, 0);
    s2(1, 1, 3'b001, 0,  3, 1, 0, 0, 0, 0, 0, 0);
    s2(1, 1, 3'b000, 0,  0, 1, 0, 0, 0, 0, 1, 1);
    s2(1, 0, 3'b000, 0,  0, 1, 0, 0, 0, 0, 0, 1);
    // skip while locked, then relock from ACQ
    s2(1, 1, 3'b010, 0,  1, 1, 0, 0, 0, 0, 0, 1);
    s2(1, 1, 3'b001, 0,  3, 0, 0, 1, 1, 1, 0, 1);
    s2(1, 1, 3'b000, 0,  0, 0, 0, 0, 1, 1, 0, 1);
    s2(1, 1, 3'b010, 0,  1, 0, 0, 0, 1, 1, 0, 1);
    s2(1, 1, 3'b011, 0,  2, 0, 0, 0, 1, 1, 0, 1);
    s2(1, 1, 3'b001, 0,  3, 1, 0, 0, 1, 1, 0, 1);
    // valid gaps of 3 cycles with junk codes on jcode
    for (int i = 0; i < 3; i++) s2(1, 0, 3'b010, 0,  3, 1, 0, 0, 1, 1, 0, 1);
    s2(1, 1, 3'b000, 0,  0, 1, 0, 0, 1, 1, 1, 2);
    for (int i = 0; i < 3; i++) s2(1, 0, 3'b011, 0,  0, 1, 0, 0, 1, 1, 0, 2);
    s2(1, 1, 3'b010, 0,  1, 1, 0, 0, 1, 1, 0, 2);
    // repeat of the same code while locked
    s2(1, 1, 3'b010, 0,  1, 0, 0, 1, 1, 2, 0, 2);
    // clear with no error
    s2(1, 0, 3'b000, 1,  1, 0, 0, 0, 0, 0, 0, 2);
    s2(1, 1, 3'b011, 0,  2, 0, 0, 0, 0, 0, 0, 2);
    s2(1, 1, 3'b001, 0,  3, 0, 0, 0, 0, 0, 0, 2);
    s2(1, 1, 3'b000, 0,  0, 0, 0, 0, 0, 0, 0, 2);
    s2(1, 1, 3'b010, 0,  1, 1, 0, 0, 0, 0, 0, 2);
    s2(1, 1, 3'b011, 0,  2, 1, 0, 0, 0, 0, 0, 2);
    s2(1, 1, 3'b001, 0,  3, 1, 0, 0, 0, 0, 0, 2);
    s2(1, 1, 3'b000, 0,  0, 1, 0, 0, 0, 0, 1, 3);
    // reset mid-lock beats valid and clear
    s2(0, 1, 3'b010, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    s2(0, 1, 3'b010, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    s2(1, 0, 3'b000, 0,  0, 0, 0, 0, 0, 0, 0, 0);

    // ---- d3: illegal codes in IDLE, lock, illegal while locked
    s3(0, 0, 3'b000, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    s3(1, 1, 3'b010, 0,  0, 0, 1, 0, 1, 1, 0, 0);
    s3(1, 1, 3'b101, 0,  0, 0, 1, 0, 1, 2, 0, 0);
    s3(1, 0, 3'b000, 0,  0, 0, 0, 0, 1, 2, 0, 0);
    s3(1, 1, 3'b000, 0,  0, 0, 0, 0, 1, 2, 0, 0);
    s3(1, 1, 3'b100, 0,  1, 0, 0, 0, 1, 2, 0, 0);
    s3(1, 1, 3'b110, 0,  2, 1, 0, 0, 1, 2, 0, 0);
    s3(1, 1, 3'b111, 0,  3, 1, 0, 0, 1, 2, 0, 0);
    s3(1, 1, 3'b010, 0,  3, 0, 1, 1, 1, 3, 0, 0);
    s3(1, 1, 3'b101, 0,  3, 0, 1, 0, 1, 4, 0, 0);
    s3(1, 1, 3'b011, 0,  4, 0, 0, 0, 1, 4, 0, 0);
    s3(1, 1, 3'b001, 0,  5, 0, 0, 0, 1, 4, 0, 0);
    s3(1, 1, 3'b000, 0,  0, 1, 0, 0, 1, 4, 0, 0);
    s3(1, 1, 3'b100, 0,  1, 1, 0, 0, 1, 4, 0, 0);
    s3(1, 1, 3'b000, 0,  0, 0, 0, 1, 1, 5, 0, 0);
    s3(1, 1, 3'b100, 0,  1, 0, 0, 0, 1, 5, 0, 0);
    s3(1, 1, 3'b110, 0,  2, 1, 0, 0, 1, 5, 0, 0);
    // clear colliding with a seq_err at err_cnt=5: error wins
    s3(1, 1, 3'b000, 1,  0, 0, 0, 1, 1, 1, 0, 0);
    s3(1, 1, 3'b100, 0,  1, 0, 0, 0, 1, 1, 0, 0);
    s3(1, 1, 3'b110, 0,  2, 1, 0, 0, 1, 1, 0, 0);
    s3(1, 1, 3'b111, 0,  3, 1, 0, 0, 1, 1, 0, 0);
    s3(1, 1, 3'b011, 0,  4, 1, 0, 0, 1, 1, 0, 0);
    s3(1, 1, 3'b001, 0,  5, 1, 0, 0, 1, 1, 0, 0);
    s3(1, 1, 3'b000, 0,  0, 1, 0, 0, 1, 1, 1, 1);
    // saturation of the 3-bit err_cnt at 7
    s3(1, 1, 3'b010, 0,  0, 0, 1, 1, 1, 2, 0, 1);
    for (int i = 3; i <= 8; i++) s3(1, 1, 3'b101, 0,  0, 0, 1, 0, 1, (i > 7) ? 7 : i, 0, 1);
    s3(1, 0, 3'b000, 1,  0, 0, 0, 0, 0, 0, 0, 1);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
